// File: rtl/sipo_comma_align.sv
// Purpose: serial-to-10b deserializer that finds K28.5 comma boundaries and tracks lock.
// Latency: 1 clk from the edge sampling a symbol's last bit to symbol_valid.
// Backpressure: none; the decoder must accept every symbol_valid strobe.
module sipo_comma_align #(
   parameter int unsigned TIMEOUT_SYMBOLS = 16
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       serial_in,
   output logic [9:0] symbol_out,
   output logic       symbol_valid,
   output logic       is_comma,
   output logic       locked,
   output logic       realign
);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [9:0] K28_5_NEG = 10'h0FA;
   localparam logic [9:0] K28_5_POS = 10'h305;
   localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_SYMBOLS);

   state_t     state_q, state_d;
   logic [9:0] w_q, w_d;
   logic [3:0] fill_q, fill_d;
   logic [3:0] bit_q, bit_d;
   logic [7:0] to_q, to_d;
   logic [9:0] sym_q, sym_d;
   logic       vld_q, vld_d;
   logic       com_q, com_d;
   logic       lock_q, lock_d;
   logic       rea_q, rea_d;

   logic [9:0] wn;
   logic       comma;
   logic       boundary;
   logic       acquire;
   logic [7:0] to_inc;

   // Next-state logic: every decision looks at the window including the bit sampled this edge.
   always_comb begin
      wn       = {w_q[8:0], serial_in};
      comma    = (wn == K28_5_NEG) || (wn == K28_5_POS);
      boundary = (bit_q == 4'd9);
      to_inc   = to_q + 8'd1;
      acquire  = 1'b0;

      w_d     = wn;
      state_d = state_q;
      fill_d  = fill_q;
      bit_d   = bit_q;
      to_d    = to_q;
      sym_d   = sym_q;
      vld_d   = 1'b0;
      com_d   = 1'b0;
      rea_d   = 1'b0;
      lock_d  = lock_q;

      case (state_q)
         ST_FILL: begin
            // The 10th bit after reset completes the first full window and is already eligible.
            if (fill_q == 4'd9) begin
               fill_d  = 4'd0;
               state_d = ST_SEARCH;
               acquire = comma;
            end else begin
               fill_d = fill_q + 4'd1;
            end
         end
         ST_SEARCH: begin
            acquire = comma;
         end
         ST_LOCKED: begin
            bit_d = boundary ? 4'd0 : bit_q + 4'd1;
            if (comma) begin
               // A comma wins over the timeout and always re-anchors the symbol phase.
               sym_d = wn;
               vld_d = 1'b1;
               com_d = 1'b1;
               rea_d = !boundary;
               bit_d = 4'd0;
               to_d  = 8'd0;
            end else if (boundary) begin
               sym_d = wn;
               vld_d = 1'b1;
               if (to_inc >= TO_LIMIT) begin
                  lock_d  = 1'b0;
                  to_d    = 8'd0;
                  state_d = ST_SEARCH;
               end else begin
                  to_d = to_inc;
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            fill_d  = 4'd0;
         end
      endcase

      if (acquire) begin
         sym_d   = wn;
         vld_d   = 1'b1;
         com_d   = 1'b1;
         lock_d  = 1'b1;
         bit_d   = 4'd0;
         to_d    = 8'd0;
         state_d = ST_LOCKED;
      end
   end

   // State and registered outputs; reset aborts any partial symbol and restarts the fill.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_FILL;
         w_q     <= 10'h000;
         fill_q  <= 4'd0;
         bit_q   <= 4'd0;
         to_q    <= 8'd0;
         sym_q   <= 10'h000;
         vld_q   <= 1'b0;
         com_q   <= 1'b0;
         lock_q  <= 1'b0;
         rea_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         fill_q  <= fill_d;
         bit_q   <= bit_d;
         to_q    <= to_d;
         sym_q   <= sym_d;
         vld_q   <= vld_d;
         com_q   <= com_d;
         lock_q  <= lock_d;
         rea_q   <= rea_d;
      end
   end

   assign symbol_out   = sym_q;
   assign symbol_valid = vld_q;
   assign is_comma     = com_q;
   assign locked       = lock_q;
   assign realign      = rea_q;

endmodule
